// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// ID/EX pipeline register with a valid/ready handshake on both sides and a
// two-entry skid buffer (main entry M plus one overflow entry S). It carries
// the decode-stage control bits, NUM_OPS operands and NUM_DST destination
// register numbers into the execute stage. It sustains one instruction per
// cycle under back-pressure and supports a flush that squashes every held
// instruction.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   flush          squash held and incoming instructions (after rst, wins)
//   in_valid       decode presents an instruction
//   in_ready       register can accept this cycle (registered, = ~S.valid)
//   in_reg_write   writeback enable of the incoming instruction
//   in_alu_op      ALU operation field, OP_W bits
//   in_data        operands, operand k at [k*DATA_W +: DATA_W]
//   in_wr_reg      destination register numbers, same packing with REG_W
//   out_valid      execute-side instruction valid (= M.valid)
//   out_ready      execute stage accepts the instruction on out_*
//   out_reg_write  writeback enable, forced low whenever out_valid is low
//   out_alu_op     ALU operation of M
//   out_data       operands of M
//   out_wr_reg     destination register numbers of M
//
// Optional feature, macro ID_EX_STATS_EN:
//   When defined, three extra 16-bit saturating outputs exist:
//     stall_cnt   cycles with out_valid & ~out_ready
//     bubble_cnt  cycles with ~out_valid & out_ready
//     flush_cnt   cycles with flush asserted
//   All are cleared by rst and update one cycle after the event. When the
//   macro is undefined these ports and counters are absent and the datapath
//   behaves identically.
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
  parameter int DATA_W  = 8,
  parameter int REG_W   = 3,
  parameter int NUM_OPS = 3,
  parameter int NUM_DST = 2,
  parameter int OP_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_reg_write,
  input  logic [OP_W-1:0]            in_alu_op,
  input  logic [NUM_OPS*DATA_W-1:0]  in_data,
  input  logic [NUM_DST*REG_W-1:0]   in_wr_reg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_reg_write,
  output logic [OP_W-1:0]            out_alu_op,
  output logic [NUM_OPS*DATA_W-1:0]  out_data,
  output logic [NUM_DST*REG_W-1:0]   out_wr_reg
`ifdef ID_EX_STATS_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                bubble_cnt,
  output logic [15:0]                flush_cnt
`endif
);

  localparam int DW = NUM_OPS * DATA_W;
  localparam int RW = NUM_DST * REG_W;

  // Occupancy of the two entries. The valid bits of M and S are decoded
  // from this state rather than stored separately, so they cannot disagree.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state_q;
  occ_e state_d;

  // Registered ready, kept as its own flop so in_ready has no
  // combinational path from out_ready.
  logic in_ready_q;

  // Main entry payload (drives the outputs)
  logic          m_reg_write;
  logic [OP_W-1:0] m_alu_op;
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_wr_reg;

  // Skid entry payload (overflow only)
  logic          s_reg_write;
  logic [OP_W-1:0] s_alu_op;
  logic [DW-1:0] s_data;
  logic [RW-1:0] s_wr_reg;

  logic m_valid;
  logic in_xfer;
  logic out_xfer;

  // Payload load strobes produced by the next-state logic
  logic load_m_from_in;
  logic load_m_from_s;
  logic load_s_from_in;

  assign m_valid  = (state_q != EMPTY);
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = m_valid & out_ready;

  // Next-state and load-strobe logic. Flush overrides every transition and
  // suppresses all payload loads, so an instruction presented during the
  // flush cycle is dropped. An output transfer during flush still happens
  // on the execute side; M simply becomes invalid afterwards.
  always_comb begin
    state_d        = state_q;
    load_m_from_in = 1'b0;
    load_m_from_s  = 1'b0;
    load_s_from_in = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d        = ONE;
            load_m_from_in = 1'b1;
          end
        end
        ONE: begin
          if (out_xfer && in_xfer) begin
            load_m_from_in = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            state_d        = FULL;
            load_s_from_in = 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path matters; S moves
          // into M to keep strict FIFO order.
          if (out_xfer) begin
            state_d       = ONE;
            load_m_from_s = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state and registered ready. Ready for the next cycle is
  // simply "S will not be holding an instruction".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Main entry payload. It only changes on an accepting transfer and is
  // deliberately left untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg_write <= 1'b0;
      m_alu_op    <= '0;
      m_data      <= '0;
      m_wr_reg    <= '0;
    end else if (load_m_from_in) begin
      m_reg_write <= in_reg_write;
      m_alu_op    <= in_alu_op;
      m_data      <= in_data;
      m_wr_reg    <= in_wr_reg;
    end else if (load_m_from_s) begin
      m_reg_write <= s_reg_write;
      m_alu_op    <= s_alu_op;
      m_data      <= s_data;
      m_wr_reg    <= s_wr_reg;
    end
  end

  // Skid entry payload, captured only when M is occupied and not draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg_write <= 1'b0;
      s_alu_op    <= '0;
      s_data      <= '0;
      s_wr_reg    <= '0;
    end else if (load_s_from_in) begin
      s_reg_write <= in_reg_write;
      s_alu_op    <= in_alu_op;
      s_data      <= in_data;
      s_wr_reg    <= in_wr_reg;
    end
  end

  // Outputs come straight from M. reg_write is gated by valid so a stale
  // payload in an empty M can never trigger a register-file write.
  assign in_ready      = in_ready_q;
  assign out_valid     = m_valid;
  assign out_reg_write = m_reg_write & m_valid;
  assign out_alu_op    = m_alu_op;
  assign out_data      = m_data;
  assign out_wr_reg    = m_wr_reg;

`ifdef ID_EX_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] bubble_q;
  logic [15:0] flush_q;

  // Saturating event counters; they stick at 16'hFFFF instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= 16'd0;
      bubble_q <= 16'd0;
      flush_q  <= 16'd0;
    end else begin
      if (m_valid && !out_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (!m_valid && out_ready && (bubble_q != 16'hFFFF)) begin
        bubble_q <= bubble_q + 16'd1;
      end
      if (flush && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_skid_reg
//
// Directed testbench for id_ex_skid_reg with default parameters
// (DATA_W=8, REG_W=3, NUM_OPS=3, NUM_DST=2, OP_W=1). Each scenario task
// drives inputs right after a rising edge and checks outputs #1 after the
// following rising edge against hand-computed values. The stats scenario is
// compiled only when ID_EX_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_skid_reg;

  localparam int DATA_W  = 8;
  localparam int REG_W   = 3;
  localparam int NUM_OPS = 3;
  localparam int NUM_DST = 2;
  localparam int OP_W    = 1;
  localparam int DW      = NUM_OPS * DATA_W;
  localparam int RW      = NUM_DST * REG_W;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_reg_write;
  logic [OP_W-1:0] in_alu_op;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_wr_reg;
  logic          out_valid;
  logic          out_ready;
  logic          out_reg_write;
  logic [OP_W-1:0] out_alu_op;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_wr_reg;
`ifdef ID_EX_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   bubble_cnt;
  logic [15:0]   flush_cnt;
`endif

  int checks;
  int passes;

  id_ex_skid_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .NUM_OPS(NUM_OPS),
    .NUM_DST(NUM_DST),
    .OP_W   (OP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_write (in_reg_write),
    .in_alu_op    (in_alu_op),
    .in_data      (in_data),
    .in_wr_reg    (in_wr_reg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_reg_write(out_reg_write),
    .out_alu_op   (out_alu_op),
    .out_data     (out_data),
    .out_wr_reg   (out_wr_reg)
`ifdef ID_EX_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [OP_W-1:0] op,
                       input logic [DW-1:0] d, input logic [RW-1:0] wr);
    in_valid     = v;
    in_reg_write = rw;
    in_alu_op    = op;
    in_data      = d;
    in_wr_reg    = wr;
  endtask

  // Reset held for two cycles with an instruction offered on the input
  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 24'hAABBCC, 6'o75);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    else passes++;
    checks++;
    if (out_reg_write !== 1'b0) $display("[TB] FAIL reset_out_reg_write: got %b want 0", out_reg_write);
    else passes++;
    checks++;
    if (out_data !== 24'h000000) $display("[TB] FAIL reset_out_data: got %h want 000000", out_data);
    else passes++;
    checks++;
    if (out_wr_reg !== 6'o00 || out_alu_op !== 1'b0)
      $display("[TB] FAIL reset_out_fields: got wr=%o op=%b want wr=00 op=0", out_wr_reg, out_alu_op);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    else passes++;
  endtask

  // Two back-to-back instructions with out_ready held high
  task automatic test_streaming();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, {8'h03, 8'h02, 8'h01}, 6'o21);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h030201 || out_wr_reg !== 6'o21 || out_alu_op !== 1'b1)
      $display("[TB] FAIL stream_first: got v=%b d=%h wr=%o op=%b want v=1 d=030201 wr=21 op=1",
               out_valid, out_data, out_wr_reg, out_alu_op);
    else passes++;
    checks++;
    if (out_reg_write !== 1'b1 || in_ready !== 1'b1)
      $display("[TB] FAIL stream_first_ctl: got rw=%b rdy=%b want rw=1 rdy=1", out_reg_write, in_ready);
    else passes++;
    drive(1'b1, 1'b0, 1'b0, {8'h06, 8'h05, 8'h04}, 6'o43);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h060504 || out_wr_reg !== 6'o43 || out_alu_op !== 1'b0)
      $display("[TB] FAIL stream_second: got v=%b d=%h wr=%o op=%b want v=1 d=060504 wr=43 op=0",
               out_valid, out_data, out_wr_reg, out_alu_op);
    else passes++;
    checks++;
    if (out_reg_write !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL stream_second_ctl: got rw=%b rdy=%b want rw=0 rdy=1", out_reg_write, in_ready);
    else passes++;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    step();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL stream_drain: got v=%b want 0", out_valid);
    else passes++;
  endtask

  // Fill M and S while execute stalls, then drain in order
  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 24'h0A0A0A, 6'o05);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_wr_reg !== 6'o05 || in_ready !== 1'b1)
      $display("[TB] FAIL bp_a_loaded: got v=%b wr=%o rdy=%b want v=1 wr=05 rdy=1",
               out_valid, out_wr_reg, in_ready);
    else passes++;
    drive(1'b1, 1'b1, 1'b1, 24'h0B0B0B, 6'o06);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_wr_reg !== 6'o05 || out_data !== 24'h0A0A0A)
      $display("[TB] FAIL bp_full: got rdy=%b wr=%o d=%h want rdy=0 wr=05 d=0a0a0a",
               in_ready, out_wr_reg, out_data);
    else passes++;
    // Offer E while full: must be ignored
    drive(1'b1, 1'b0, 1'b0, 24'h0E0E0E, 6'o07);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_wr_reg !== 6'o05 || out_valid !== 1'b1)
      $display("[TB] FAIL bp_hold: got rdy=%b wr=%o v=%b want rdy=0 wr=05 v=1",
               in_ready, out_wr_reg, out_valid);
    else passes++;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_wr_reg !== 6'o06 || out_data !== 24'h0B0B0B || out_alu_op !== 1'b1)
      $display("[TB] FAIL bp_b_out: got v=%b wr=%o d=%h op=%b want v=1 wr=06 d=0b0b0b op=1",
               out_valid, out_wr_reg, out_data, out_alu_op);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_back: got %b want 1", in_ready);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL bp_empty: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else passes++;
  endtask

  // Flush while full with C offered; C must vanish, D follows normally
  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 24'h111111, 6'o11);
    step();
    drive(1'b1, 1'b1, 1'b0, 24'h222222, 6'o22);
    step();
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL flush_prefull: got rdy=%b want 0", in_ready);
    else passes++;
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 24'hCCCCCC, 6'o33);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0)
      $display("[TB] FAIL flush_empty: got v=%b rdy=%b rw=%b want v=0 rdy=1 rw=0",
               out_valid, in_ready, out_reg_write);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_c_gone: got v=%b want 0", out_valid);
    else passes++;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 24'hDDDDDD, 6'o44);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hDDDDDD || out_wr_reg !== 6'o44)
      $display("[TB] FAIL flush_d_out: got v=%b d=%h wr=%o want v=1 d=dddddd wr=44",
               out_valid, out_data, out_wr_reg);
    else passes++;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    step();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_d_drain: got v=%b want 0", out_valid);
    else passes++;
  endtask

  // reg_write without valid must never reach the output
  task automatic test_bubble_gating();
    out_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 24'h777777, 6'o77);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_reg_write !== 1'b0 || out_valid !== 1'b0)
        $display("[TB] FAIL bubble_gate_%0d: got rw=%b v=%b want rw=0 v=0", i, out_reg_write, out_valid);
      else passes++;
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
  endtask

`ifdef ID_EX_STATS_EN
  // 3 stalls, 2 flushes, 0x10010 bubbles from a fresh reset
  task automatic test_stats();
    out_ready = 1'b0;
    flush     = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h555555, 6'o55);
    step();
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    for (int i = 0; i < 3; i++) step();
    // First flush drains M with out_ready high, so no stall and no bubble
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32'h10010; i++) @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (stall_cnt !== 16'd3) $display("[TB] FAIL stats_stall: got %0d want 3", stall_cnt);
    else passes++;
    checks++;
    if (flush_cnt !== 16'd2) $display("[TB] FAIL stats_flush: got %0d want 2", flush_cnt);
    else passes++;
    checks++;
    if (bubble_cnt !== 16'hFFFF) $display("[TB] FAIL stats_bubble: got %h want ffff", bubble_cnt);
    else passes++;
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 6'o00);
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble_gating();
`ifdef ID_EX_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
